// File: rtl/n101_hclkgen_seq_pkg.sv
// ---------------------------------------------------------------------------
// n101_hclkgen_seq_pkg
// Shared definitions for the HCLK PLL power-up / reconfiguration sequencer:
//   - seq_state_e : sequencer state encoding
//   - OD_RST / M_RST / N_RST : power-on values of the applied PLL settings
// ---------------------------------------------------------------------------
package n101_hclkgen_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_RST       = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4,
    ST_SLEEP     = 3'd5
  } seq_state_e;

  localparam logic [1:0] OD_RST = 2'b10;
  localparam logic [7:0] M_RST  = 8'h32;
  localparam logic [4:0] N_RST  = 5'h02;

endpackage

// File: rtl/n101_gnrl_sync.sv
// ---------------------------------------------------------------------------
// n101_gnrl_sync
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset (both flops clear to RST_VAL)
//   d     in  asynchronous input
//   q     out synchronized output, two clk cycles of latency
// ---------------------------------------------------------------------------
module n101_gnrl_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/n101_hclkgen_seq.sv
// ---------------------------------------------------------------------------
// n101_hclkgen_seq
// PLL power-up and reconfiguration sequencer. Drives the PLL macro pins in a
// safe order: bypass before touching the PLL, hold reset for RST_CYC cycles,
// switch the PLL in only after a synchronized lock.
//
// Build option:
//   N101_HCLKGEN_SEQ_TIMEOUT_EN : when defined, WAIT_LOCK gives up after
//   LOCK_TO cycles and raises the sticky lock_to_err. When undefined,
//   WAIT_LOCK waits forever, lock_to_err is 0 and err_clr is ignored.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_pll_RESET/ASLEEP        requested PLL reset / sleep
//   req_pllbypass               requested bypass (honoured only in RUN)
//   req_pll_OD/M/N              requested divider settings
//   hfxoscen                    reference oscillator enable
//   pll_lock                    PLL lock flag (asynchronous)
//   err_clr                     pulse clearing lock_to_err
//   pll_RESET/ASLEEP, pllbypass registered PLL pins
//   pll_OD/M/N                  applied (shadow) divider settings
//   seq_busy                    sequencer in a transitional state
//   pll_locked                  PLL in use (RUN)
//   lock_to_err                 sticky lock timeout flag
// ---------------------------------------------------------------------------
module n101_hclkgen_seq
  import n101_hclkgen_seq_pkg::*;
#(
  parameter int unsigned RST_CYC = 16,
  parameter int unsigned BYP_CYC = 4,
  parameter int unsigned LOCK_TO = 4095,
  parameter int unsigned CW      = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_pll_RESET,
  input  logic       req_pll_ASLEEP,
  input  logic       req_pllbypass,
  input  logic [1:0] req_pll_OD,
  input  logic [7:0] req_pll_M,
  input  logic [4:0] req_pll_N,
  input  logic       hfxoscen,
  input  logic       pll_lock,
  input  logic       err_clr,
  output logic       pll_RESET,
  output logic       pll_ASLEEP,
  output logic       pllbypass,
  output logic [1:0] pll_OD,
  output logic [7:0] pll_M,
  output logic [4:0] pll_N,
  output logic       seq_busy,
  output logic       pll_locked,
  output logic       lock_to_err
);

  localparam logic [CW-1:0] RST_LD  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] BYP_LD  = CW'(BYP_CYC - 1);
  localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_TO - 1);

  seq_state_e    state;
  seq_state_e    dest;
  logic [CW-1:0] cnt;
  logic          lock_s;
  logic          abort;
  logic          shadow_diff;
  logic          start_ok;
  logic          timeout_hit;

  n101_gnrl_sync #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Losing the reference clock leaves nothing to sequence with, so every
  // active state drops straight to OFF; a reset request does the same where
  // the PLL is not yet (or no longer) driving the clock.
  assign abort = (state != ST_OFF) &&
                 (!hfxoscen ||
                  (req_pll_RESET && (state inside {ST_RST, ST_WAIT_LOCK, ST_SLEEP})));

  assign shadow_diff = ({req_pll_OD, req_pll_M, req_pll_N} != {pll_OD, pll_M, pll_N});
  assign start_ok    = hfxoscen && !req_pll_RESET && !req_pll_ASLEEP && !lock_to_err;

`ifdef N101_HCLKGEN_SEQ_TIMEOUT_EN
  assign timeout_hit = (state == ST_WAIT_LOCK) && !abort && !lock_s && (cnt == '0);

  // Sticky timeout flag; a timeout in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_to_err <= 1'b0;
    end else if (timeout_hit) begin
      lock_to_err <= 1'b1;
    end else if (err_clr) begin
      lock_to_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign timeout_hit    = 1'b0;
  assign lock_to_err    = 1'b0;
`endif

  // Sequencer. Pins and status are written together with the state so each
  // output reflects the state being entered, one cycle after the decision.
  // The counter reloads on state entry and otherwise saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      dest       <= ST_OFF;
      cnt        <= '0;
      pll_RESET  <= 1'b1;
      pll_ASLEEP <= 1'b0;
      pllbypass  <= 1'b1;
      pll_OD     <= OD_RST;
      pll_M      <= M_RST;
      pll_N      <= N_RST;
      seq_busy   <= 1'b0;
      pll_locked <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (abort || timeout_hit ||
          (state == ST_HOLD && cnt == '0 && dest == ST_OFF) ||
          !(state inside {ST_OFF, ST_RST, ST_WAIT_LOCK, ST_RUN, ST_HOLD, ST_SLEEP})) begin
        state      <= ST_OFF;
        cnt        <= '0;
        pll_RESET  <= 1'b1;
        pll_ASLEEP <= 1'b0;
        pllbypass  <= 1'b1;
        seq_busy   <= 1'b0;
        pll_locked <= 1'b0;
      end else begin
        case (state)
          ST_OFF, ST_SLEEP: begin
            if (start_ok) begin
              // Shadow settings are only captured when starting a fresh lock.
              state      <= ST_RST;
              cnt        <= RST_LD;
              pll_OD     <= req_pll_OD;
              pll_M      <= req_pll_M;
              pll_N      <= req_pll_N;
              pll_RESET  <= 1'b1;
              pll_ASLEEP <= 1'b0;
              pllbypass  <= 1'b1;
              seq_busy   <= 1'b1;
            end
          end
          ST_RST: begin
            if (cnt == '0) begin
              state     <= ST_WAIT_LOCK;
              cnt       <= LOCK_LD;
              pll_RESET <= 1'b0;
              pllbypass <= 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_s) begin
              state      <= ST_RUN;
              cnt        <= '0;
              seq_busy   <= 1'b0;
              pll_locked <= 1'b1;
            end
          end
          ST_RUN: begin
            if (req_pll_RESET || !lock_s || shadow_diff || req_pll_ASLEEP) begin
              // Any reason to restart outranks a sleep request.
              state      <= ST_HOLD;
              dest       <= (req_pll_RESET || !lock_s || shadow_diff) ? ST_OFF : ST_SLEEP;
              cnt        <= BYP_LD;
              pllbypass  <= 1'b1;
              seq_busy   <= 1'b1;
              pll_locked <= 1'b0;
            end else begin
              pllbypass <= req_pllbypass;
            end
          end
          ST_HOLD: begin
            if (cnt == '0) begin
              state      <= ST_SLEEP;
              pll_ASLEEP <= 1'b1;
              pll_RESET  <= 1'b0;
              pllbypass  <= 1'b1;
              seq_busy   <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_n101_hclkgen_seq.sv
// ---------------------------------------------------------------------------
// tb_n101_hclkgen_seq
// Directed bench for the PLL sequencer. Pins are checked as the vector
// {pll_RESET, pll_ASLEEP, pllbypass, seq_busy, pll_locked}:
//   OFF 10100, RST 10110, WAIT_LOCK/HOLD 00110, RUN entry 00101,
//   RUN with bypass released 00001, SLEEP 01100.
// ---------------------------------------------------------------------------
module tb_n101_hclkgen_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_pll_RESET, req_pll_ASLEEP, req_pllbypass;
  logic [1:0] req_pll_OD;
  logic [7:0] req_pll_M;
  logic [4:0] req_pll_N;
  logic       hfxoscen, pll_lock, err_clr;
  logic       pll_RESET, pll_ASLEEP, pllbypass;
  logic [1:0] pll_OD;
  logic [7:0] pll_M;
  logic [4:0] pll_N;
  logic       seq_busy, pll_locked, lock_to_err;

  logic [4:0]  pins;
  logic [14:0] shadow;
  localparam logic [14:0] SHADOW_RST = {2'b10, 8'h32, 5'h02};

  int n_cmp = 0;
  int n_bad = 0;

  assign pins   = {pll_RESET, pll_ASLEEP, pllbypass, seq_busy, pll_locked};
  assign shadow = {pll_OD, pll_M, pll_N};

  n101_hclkgen_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_pll_RESET  (req_pll_RESET),
    .req_pll_ASLEEP (req_pll_ASLEEP),
    .req_pllbypass  (req_pllbypass),
    .req_pll_OD     (req_pll_OD),
    .req_pll_M      (req_pll_M),
    .req_pll_N      (req_pll_N),
    .hfxoscen       (hfxoscen),
    .pll_lock       (pll_lock),
    .err_clr        (err_clr),
    .pll_RESET      (pll_RESET),
    .pll_ASLEEP     (pll_ASLEEP),
    .pllbypass      (pllbypass),
    .pll_OD         (pll_OD),
    .pll_M          (pll_M),
    .pll_N          (pll_N),
    .seq_busy       (seq_busy),
    .pll_locked     (pll_locked),
    .lock_to_err    (lock_to_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_pll_RESET = 1'b1; req_pll_ASLEEP = 1'b0; req_pllbypass = 1'b0;
    req_pll_OD = 2'b10; req_pll_M = 8'h32; req_pll_N = 5'h02;
    hfxoscen = 1'b0; pll_lock = 1'b0; err_clr = 1'b0;
    tick(2);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL rst_pins: got %b want %b", pins, 5'b10100); end
    n_cmp++; if (shadow !== SHADOW_RST) begin n_bad++; $display("[TB] FAIL rst_shadow: got %h want %h", shadow, SHADOW_RST); end
    n_cmp++; if (lock_to_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err: got %b want 0", lock_to_err); end
    rst_n = 1'b1;
    tick(3);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL off_idle: got %b want %b", pins, 5'b10100); end
  endtask

  task automatic test_power_up;
    hfxoscen = 1'b1; req_pll_RESET = 1'b0;
    tick(1);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL pu_rst_entry: got %b want %b", pins, 5'b10110); end
    tick(15);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL pu_rst_last: got %b want %b", pins, 5'b10110); end
    tick(1);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL pu_wait: got %b want %b", pins, 5'b00110); end
    pll_lock = 1'b1;
    tick(2);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL pu_sync_delay: got %b want %b", pins, 5'b00110); end
    tick(1);
    n_cmp++; if (pins !== 5'b00101) begin n_bad++; $display("[TB] FAIL pu_run_entry: got %b want %b", pins, 5'b00101); end
    tick(1);
    n_cmp++; if (pins !== 5'b00001) begin n_bad++; $display("[TB] FAIL pu_bypass_off: got %b want %b", pins, 5'b00001); end
    req_pllbypass = 1'b1;
    tick(1);
    n_cmp++; if (pins !== 5'b00101) begin n_bad++; $display("[TB] FAIL run_bypass_on: got %b want %b", pins, 5'b00101); end
    req_pllbypass = 1'b0;
    tick(1);
    n_cmp++; if (pins !== 5'b00001) begin n_bad++; $display("[TB] FAIL run_bypass_back: got %b want %b", pins, 5'b00001); end
  endtask

  task automatic test_m_change;
    req_pll_M = 8'h40;
    tick(1);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL m_hold_entry: got %b want %b", pins, 5'b00110); end
    tick(3);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL m_hold_last: got %b want %b", pins, 5'b00110); end
    tick(1);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL m_off: got %b want %b", pins, 5'b10100); end
    n_cmp++; if (pll_M !== 8'h32) begin n_bad++; $display("[TB] FAIL m_shadow_old: got %h want 32", pll_M); end
    tick(1);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL m_rst: got %b want %b", pins, 5'b10110); end
    n_cmp++; if (pll_M !== 8'h40) begin n_bad++; $display("[TB] FAIL m_shadow_new: got %h want 40", pll_M); end
    tick(16);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL m_wait: got %b want %b", pins, 5'b00110); end
    tick(1);
    n_cmp++; if (pins !== 5'b00101) begin n_bad++; $display("[TB] FAIL m_relock: got %b want %b", pins, 5'b00101); end
    tick(1);
  endtask

  task automatic test_sleep;
    req_pll_ASLEEP = 1'b1;
    tick(4);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL sl_hold_last: got %b want %b", pins, 5'b00110); end
    tick(1);
    n_cmp++; if (pins !== 5'b01100) begin n_bad++; $display("[TB] FAIL sl_sleep: got %b want %b", pins, 5'b01100); end
    req_pll_ASLEEP = 1'b0;
    tick(1);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL sl_wake_rst: got %b want %b", pins, 5'b10110); end
    tick(15);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL sl_rst_last: got %b want %b", pins, 5'b10110); end
    tick(1);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL sl_wait: got %b want %b", pins, 5'b00110); end
    tick(1);
    n_cmp++; if (pins !== 5'b00101) begin n_bad++; $display("[TB] FAIL sl_relock: got %b want %b", pins, 5'b00101); end
    tick(1);
  endtask

  task automatic test_priority;
    req_pll_ASLEEP = 1'b1; req_pll_RESET = 1'b1;
    tick(1);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL pr_hold: got %b want %b", pins, 5'b00110); end
    tick(4);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL pr_off_not_sleep: got %b want %b", pins, 5'b10100); end
    tick(3);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL pr_off_stays: got %b want %b", pins, 5'b10100); end
    req_pll_ASLEEP = 1'b0;
  endtask

  task automatic test_hfxosc_drop;
    pll_lock = 1'b0;
    tick(3);
    req_pll_RESET = 1'b0;
    tick(17);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL hx_wait: got %b want %b", pins, 5'b00110); end
    hfxoscen = 1'b0;
    tick(1);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL hx_off_now: got %b want %b", pins, 5'b10100); end
    tick(3);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL hx_off_stays: got %b want %b", pins, 5'b10100); end
  endtask

  task automatic test_timeout;
    int waited;
    hfxoscen = 1'b1;
    tick(1);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL to_rst: got %b want %b", pins, 5'b10110); end
    tick(16);
`ifdef N101_HCLKGEN_SEQ_TIMEOUT_EN
    tick(4094);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL to_wait_last: got %b want %b", pins, 5'b00110); end
    n_cmp++; if (lock_to_err !== 1'b0) begin n_bad++; $display("[TB] FAIL to_err_early: got %b want 0", lock_to_err); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL to_off: got %b want %b", pins, 5'b10100); end
    n_cmp++; if (lock_to_err !== 1'b1) begin n_bad++; $display("[TB] FAIL to_set_wins: got %b want 1", lock_to_err); end
    tick(4);
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL to_off_blocked: got %b want %b", pins, 5'b10100); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    n_cmp++; if (lock_to_err !== 1'b0) begin n_bad++; $display("[TB] FAIL to_err_clear: got %b want 0", lock_to_err); end
    tick(1);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL to_restart: got %b want %b", pins, 5'b10110); end
`else
    tick(4095);
    n_cmp++; if (pins !== 5'b00110) begin n_bad++; $display("[TB] FAIL nto_still_wait: got %b want %b", pins, 5'b00110); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    n_cmp++; if (lock_to_err !== 1'b0) begin n_bad++; $display("[TB] FAIL nto_err_tied: got %b want 0", lock_to_err); end
`endif
    pll_lock = 1'b1;
    waited = 0;
    while (pll_locked !== 1'b1 && waited < 50) begin
      tick(1);
      waited++;
    end
    n_cmp++; if (pll_locked !== 1'b1) begin n_bad++; $display("[TB] FAIL to_final_lock: got %b want 1 after %0d cycles", pll_locked, waited); end
    tick(1);
  endtask

  task automatic test_async_reset;
    req_pllbypass = 1'b1;
    tick(1);
    n_cmp++; if (pins !== 5'b00101) begin n_bad++; $display("[TB] FAIL ar_run: got %b want %b", pins, 5'b00101); end
    n_cmp++; if (pll_M !== 8'h40) begin n_bad++; $display("[TB] FAIL ar_shadow_before: got %h want 40", pll_M); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (pins !== 5'b10100) begin n_bad++; $display("[TB] FAIL ar_pins: got %b want %b", pins, 5'b10100); end
    n_cmp++; if (shadow !== SHADOW_RST) begin n_bad++; $display("[TB] FAIL ar_shadow: got %h want %h", shadow, SHADOW_RST); end
    n_cmp++; if (lock_to_err !== 1'b0) begin n_bad++; $display("[TB] FAIL ar_err: got %b want 0", lock_to_err); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    n_cmp++; if (pins !== 5'b10110) begin n_bad++; $display("[TB] FAIL ar_restart: got %b want %b", pins, 5'b10110); end
  endtask

  initial begin
    test_reset;
    test_power_up;
    test_m_change;
    test_sleep;
    test_priority;
    test_hfxosc_drop;
    test_timeout;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
